micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 opcode  input  6  instruction opcode field; held stable by the datapath while state is 1, 2 or 6.
REQ-004 funct  input  6  instruction funct field; same stability rule as opcode.
REQ-005 addr_ctl  input  2  sequencing field from the external control ROM, indexed by state: 00 NEXT, 01 DISP1, 10 DISP2, 11 FETCH.
REQ-006 stall  input  1  memory wait; holds the current state.
REQ-007 mdu_busy  input  1  multiply/divide unit busy; holds states 20, 21 and 22 only.
REQ-008 state  output  5  registered micro-PC; drives the control ROM address.
REQ-009 illegal_op  output  1  registered one-cycle pulse on entry to state 31.
REQ-010 instr_done  output  1  registered one-cycle pulse on each FETCH transition into state 0.
REQ-011 instr_count  output  32  retired-instruction count, present only under the configuration macro.

Function
REQ-012 Next-state priority, highest first: stall, then mdu_busy in states 20/21/22, then addr_ctl.
REQ-013 A hold keeps state unchanged, does not pulse illegal_op or instr_done, and does not sample opcode or funct.
REQ-014 NEXT: state+1 in 5-bit arithmetic; 31 wraps to 0; wrap is not a FETCH and does not pulse instr_done.
REQ-015 FETCH: next state 0; instr_done=1 in the following cycle.
REQ-016 DISP1 decodes opcode: 000000 -> 6; 100011 (lw), 101011 (sw), 001000 (addi), 001101 (ori) -> 2; 000100 (beq) -> 8; 000010 (j) -> 9; any other opcode is a miss.
REQ-017 DISP2 with opcode 000000 decodes funct: 011010 (div) and 011000 (mult) -> 20; 000101 (madd) -> 21; 000110 (msub) -> 22; any other funct is a miss.
REQ-018 DISP2 with a nonzero opcode decodes opcode: 100011 -> 23; 101011 -> 24; 001000 and 001101 -> 25; any other opcode is a miss.
REQ-019 Dispatch miss: next state 31; illegal_op=1 in the following cycle; the next sequence is then taken from the ROM's addr_ctl for state 31.
REQ-020 Dispatch decode is fully specified; no latch is inferred and no X propagates for any opcode or funct value.
REQ-021 illegal_op and instr_done are mutually exclusive and each is high for exactly one cycle per event.
REQ-022 mdu_busy outside states 20/21/22 is ignored.
REQ-023 stall asserted in the same cycle as a dispatch means the dispatch is not taken; it is evaluated in the first unstalled cycle.

Reset
REQ-024 While rst_n=0: state=0, illegal_op=0, instr_done=0, instr_count=0, applied asynchronously.
REQ-025 Reset asserted mid-sequence, including during an MDU hold or a stall, aborts immediately; no pulse is emitted on reset release.
REQ-026 The first rising edge after rst_n deasserts evaluates addr_ctl for state 0.

Configuration
REQ-027 Macro MSEQ_PERF_COUNT_EN defined: instr_count increments by 1 on every cycle in which instr_done=1, and wraps from 0xFFFFFFFF to 0.
REQ-028 Macro MSEQ_PERF_COUNT_EN undefined: instr_count remains a port, tied to constant 0, with no counter register inferred.

Verification
REQ-029 Reset, then addr_ctl=00 for 3 cycles -> state sequence 0,1,2,3; instr_done=0 throughout.
REQ-030 state=1, addr_ctl=01, opcode=100011 -> state 2; then addr_ctl=10 -> state 23; then addr_ctl=11 -> state 0 with instr_done=1 for one cycle; instr_count=1 when the macro is defined.
REQ-031 state=6, addr_ctl=10, opcode=0, funct=011010, mdu_busy=1 for 5 cycles -> state 20 held for 5 cycles, then advances per addr_ctl once mdu_busy=0.
REQ-032 state=1, addr_ctl=01, opcode=111111 -> state 31 with illegal_op=1 for exactly one cycle; repeat with funct=101010 at a DISP2 in state 6 -> same result.
REQ-033 stall=1 and mdu_busy=1 together in state 21 for 2 cycles, stall then dropping while mdu_busy stays 1 -> state 21 held throughout; then rst_n pulsed low mid-hold -> state=0 and all outputs 0 immediately, with no pulse after release.

Source files
------------

// File: rtl/micro_sequencer.sv
// Micro-PC sequencer: NEXT / DISP1 / DISP2 / FETCH sequencing with stall and MDU holds.
// Define MSEQ_PERF_COUNT_EN to build the retired-instruction counter behind instr_count.
module micro_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [1:0]  addr_ctl,
  input  logic        stall,
  input  logic        mdu_busy,
  output logic [4:0]  state,
  output logic        illegal_op,
  output logic        instr_done,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    SEQ_NEXT  = 2'b00,
    SEQ_DISP1 = 2'b01,
    SEQ_DISP2 = 2'b10,
    SEQ_FETCH = 2'b11
  } seq_e;

  typedef struct packed {
    logic       hit;
    logic [4:0] target;
  } disp_t;

  localparam logic [4:0] ST_ILLEGAL = 5'd31;

  function automatic disp_t decode_disp1(input logic [5:0] op);
    disp_t d;
    d = '{hit: 1'b1, target: 5'd0};
    case (op)
      6'b000000:                                  d.target = 5'd6;
      6'b100011, 6'b101011, 6'b001000, 6'b001101: d.target = 5'd2;
      6'b000100:                                  d.target = 5'd8;
      6'b000010:                                  d.target = 5'd9;
      default:                                    d.hit    = 1'b0;
    endcase
    return d;
  endfunction

  // R-type ops dispatch on funct; everything else dispatches on opcode.
  function automatic disp_t decode_disp2(input logic [5:0] op, input logic [5:0] fn);
    disp_t d;
    d = '{hit: 1'b1, target: 5'd0};
    if (op == 6'b000000) begin
      case (fn)
        6'b011010, 6'b011000: d.target = 5'd20;
        6'b000101:            d.target = 5'd21;
        6'b000110:            d.target = 5'd22;
        default:              d.hit    = 1'b0;
      endcase
    end else begin
      case (op)
        6'b100011:            d.target = 5'd23;
        6'b101011:            d.target = 5'd24;
        6'b001000, 6'b001101: d.target = 5'd25;
        default:              d.hit    = 1'b0;
      endcase
    end
    return d;
  endfunction

  logic [4:0] state_d;
  logic       illegal_d;
  logic       done_d;
  logic       mdu_hold;
  logic       hold;
  disp_t      disp;

  assign mdu_hold = mdu_busy && (state == 5'd20 || state == 5'd21 || state == 5'd22);
  assign hold     = stall || mdu_hold;

  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    illegal_d = 1'b0;
    done_d    = 1'b0;
    disp      = '{hit: 1'b0, target: 5'd0};
    if (!hold) begin
      case (seq_e'(addr_ctl))
        SEQ_NEXT:  state_d = state + 5'd1;
        SEQ_DISP1: disp    = decode_disp1(opcode);
        SEQ_DISP2: disp    = decode_disp2(opcode, funct);
        SEQ_FETCH: begin
          state_d = 5'd0;
          done_d  = 1'b1;
        end
        default:   state_d = state;
      endcase
      if (addr_ctl == SEQ_DISP1 || addr_ctl == SEQ_DISP2) begin
        state_d   = disp.hit ? disp.target : ST_ILLEGAL;
        illegal_d = !disp.hit;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= 5'd0;
      illegal_op <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      state      <= state_d;
      illegal_op <= illegal_d;
      instr_done <= done_d;
    end
  end

`ifdef MSEQ_PERF_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          count_q <= 32'd0;
    else if (instr_done) count_q <= count_q + 32'd1;
  end

  assign instr_count = count_q;
`else
  assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer: sequencing, dispatch decode,
// holds, pulses and asynchronous reset.
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [1:0]  addr_ctl;
  logic        stall;
  logic        mdu_busy;
  logic [4:0]  state;
  logic        illegal_op;
  logic        instr_done;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] A_NEXT = 2'b00, A_D1 = 2'b01, A_D2 = 2'b10, A_FETCH = 2'b11;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .addr_ctl(addr_ctl),
    .stall(stall), .mdu_busy(mdu_busy), .state(state), .illegal_op(illegal_op),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, state=%0d required=finish", state);
    $fatal(1, "watchdog");
  end

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    opcode   = '0;
    funct    = '0;
    addr_ctl = A_NEXT;
    stall    = 1'b0;
    mdu_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic goto(input logic [4:0] target);
    do_reset();
    addr_ctl = A_NEXT;
    for (int i = 0; i < int'(target); i++) step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    opcode   = '0;
    funct    = '0;
    addr_ctl = A_NEXT;
    stall    = 1'b0;
    mdu_busy = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== 5'd0 || illegal_op !== 1'b0 || instr_done !== 1'b0 || instr_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_values: state=%0d ill=%b done=%b cnt=%0d required 0/0/0/0",
               state, illegal_op, instr_done, instr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_next_seq();
    goto(5'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (state !== 5'(i) || instr_done !== 1'b0) begin
        bad++;
        $display("FAIL next_seq[%0d]: state=%0d done=%b required state=%0d done=0",
                 i, state, instr_done, i);
      end
    end
    goto(5'd31);
    step();
    total++;
    if (state !== 5'd0 || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL next_wrap: state=%0d done=%b required state=0 done=0", state, instr_done);
    end
  endtask

  task automatic test_lw_path();
    goto(5'd1);
    addr_ctl = A_D1;
    opcode   = 6'b100011;
    step();
    total++;
    if (state !== 5'd2) begin bad++; $display("FAIL lw_disp1: state=%0d required 2", state); end
    addr_ctl = A_D2;
    step();
    total++;
    if (state !== 5'd23) begin bad++; $display("FAIL lw_disp2: state=%0d required 23", state); end
    addr_ctl = A_FETCH;
    step();
    total++;
    if (state !== 5'd0 || instr_done !== 1'b1 || illegal_op !== 1'b0) begin
      bad++;
      $display("FAIL lw_fetch: state=%0d done=%b ill=%b required 0/1/0", state, instr_done, illegal_op);
    end
    addr_ctl = A_NEXT;
    step();
    total++;
    if (state !== 5'd1 || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL lw_done_pulse: state=%0d done=%b required 1/0", state, instr_done);
    end
`ifdef MSEQ_PERF_COUNT_EN
    total++;
    if (instr_count !== 32'd1) begin bad++; $display("FAIL lw_count: cnt=%0d required 1", instr_count); end
`else
    total++;
    if (instr_count !== 32'd0) begin bad++; $display("FAIL lw_count: cnt=%0d required 0", instr_count); end
`endif
  endtask

  task automatic run_vec(input string name, input logic [4:0] start, input logic [1:0] ac,
                         input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] exp_state, input logic exp_ill);
    goto(start);
    addr_ctl = ac;
    opcode   = op;
    funct    = fn;
    step();
    total++;
    if (state !== exp_state || illegal_op !== exp_ill || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL %s: state=%0d ill=%b done=%b required state=%0d ill=%b done=0",
               name, state, illegal_op, instr_done, exp_state, exp_ill);
    end
    if (exp_ill) begin
      addr_ctl = A_NEXT;
      step();
      total++;
      if (state !== 5'd0 || illegal_op !== 1'b0) begin
        bad++;
        $display("FAIL %s_after: state=%0d ill=%b required state=0 ill=0", name, state, illegal_op);
      end
    end
  endtask

  task automatic test_dispatch();
    run_vec("d1_rtype", 5'd1, A_D1, 6'b000000, 6'b000000, 5'd6,  1'b0);
    run_vec("d1_addi",  5'd1, A_D1, 6'b001000, 6'b000000, 5'd2,  1'b0);
    run_vec("d1_beq",   5'd1, A_D1, 6'b000100, 6'b000000, 5'd8,  1'b0);
    run_vec("d1_j",     5'd1, A_D1, 6'b000010, 6'b000000, 5'd9,  1'b0);
    run_vec("d1_miss",  5'd1, A_D1, 6'b111111, 6'b000000, 5'd31, 1'b1);
    run_vec("d2_mult",  5'd6, A_D2, 6'b000000, 6'b011000, 5'd20, 1'b0);
    run_vec("d2_madd",  5'd6, A_D2, 6'b000000, 6'b000101, 5'd21, 1'b0);
    run_vec("d2_msub",  5'd6, A_D2, 6'b000000, 6'b000110, 5'd22, 1'b0);
    run_vec("d2_fmiss", 5'd6, A_D2, 6'b000000, 6'b101010, 5'd31, 1'b1);
    run_vec("d2_sw",    5'd2, A_D2, 6'b101011, 6'b000000, 5'd24, 1'b0);
    run_vec("d2_ori",   5'd2, A_D2, 6'b001101, 6'b000000, 5'd25, 1'b0);
    run_vec("d2_omiss", 5'd2, A_D2, 6'b000100, 6'b000000, 5'd31, 1'b1);
  endtask

  task automatic test_mdu_hold();
    goto(5'd6);
    addr_ctl = A_D2;
    funct    = 6'b011010;
    mdu_busy = 1'b1;
    step();
    total++;
    if (state !== 5'd20) begin bad++; $display("FAIL mdu_entry: state=%0d required 20", state); end
    addr_ctl = A_NEXT;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (state !== 5'd20 || instr_done !== 1'b0) begin
        bad++;
        $display("FAIL mdu_hold[%0d]: state=%0d done=%b required 20/0", i, state, instr_done);
      end
    end
    mdu_busy = 1'b0;
    step();
    total++;
    if (state !== 5'd21) begin bad++; $display("FAIL mdu_release: state=%0d required 21", state); end
  endtask

  task automatic test_stall();
    goto(5'd1);
    stall    = 1'b1;
    addr_ctl = A_D1;
    opcode   = 6'b000100;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (state !== 5'd1 || illegal_op !== 1'b0) begin
        bad++;
        $display("FAIL stall_disp[%0d]: state=%0d ill=%b required 1/0", i, state, illegal_op);
      end
    end
    stall = 1'b0;
    step();
    total++;
    if (state !== 5'd8) begin bad++; $display("FAIL stall_release: state=%0d required 8", state); end
    stall    = 1'b1;
    addr_ctl = A_FETCH;
    step();
    total++;
    if (state !== 5'd8 || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL stall_fetch: state=%0d done=%b required 8/0", state, instr_done);
    end
  endtask

  task automatic test_back_to_back();
    goto(5'd0);
    addr_ctl = A_FETCH;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (state !== 5'd0 || instr_done !== 1'b1) begin
        bad++;
        $display("FAIL b2b_fetch[%0d]: state=%0d done=%b required 0/1", i, state, instr_done);
      end
    end
    addr_ctl = A_NEXT;
    step();
`ifdef MSEQ_PERF_COUNT_EN
    total++;
    if (instr_count !== 32'd2) begin bad++; $display("FAIL b2b_count: cnt=%0d required 2", instr_count); end
`endif
    total++;
    if (state !== 5'd1 || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: state=%0d done=%b required 1/0", state, instr_done);
    end
  endtask

  task automatic test_stall_mdu_reset();
    goto(5'd6);
    addr_ctl = A_D2;
    funct    = 6'b000101;
    step();
    stall    = 1'b1;
    mdu_busy = 1'b1;
    addr_ctl = A_FETCH;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) stall = 1'b0;
      step();
      total++;
      if (state !== 5'd21 || instr_done !== 1'b0) begin
        bad++;
        $display("FAIL stall_mdu[%0d]: state=%0d done=%b required 21/0", i, state, instr_done);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (state !== 5'd0 || illegal_op !== 1'b0 || instr_done !== 1'b0 || instr_count !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset: state=%0d ill=%b done=%b cnt=%0d required 0/0/0/0",
               state, illegal_op, instr_done, instr_count);
    end
    mdu_busy = 1'b0;
    addr_ctl = A_NEXT;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    total++;
    if (state !== 5'd1 || illegal_op !== 1'b0 || instr_done !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: state=%0d ill=%b done=%b required 1/0/0", state, illegal_op, instr_done);
    end
  endtask

  initial begin
    test_reset();
    test_next_seq();
    test_lw_path();
    test_dispatch();
    test_mdu_hold();
    test_stall();
    test_back_to_back();
    test_stall_mdu_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
